// File: rtl/snake_body_scan.sv
// Scans snake body segments over a synchronous read port and reports whether a query cell is occupied.
// Optional macro SCAN_EARLY_EXIT_EN: abort the scan on the first match instead of always scanning all segments.
module snake_body_scan #(
  parameter int XW        = 6,
  parameter int YW        = 5,
  parameter int MAX_LEN   = 128,
  parameter int AW        = 7,
  parameter int SKIP_HEAD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [XW+YW-1:0]  query_xy,
  input  logic [7:0]        length,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [XW+YW-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [7:0]        hit_index
);

  localparam int          DW        = XW + YW;
  localparam logic [7:0]  START_IDX = 8'((SKIP_HEAD != 0) ? 1 : 0);
  localparam logic [7:0]  MAX_L     = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   query_q;
  logic [7:0]      len_q;
  logic [7:0]      len_clamped;
  logic [7:0]      idx;
  logic [7:0]      idx_pipe;
  logic            pipe_vld;
  logic            accept;
  logic            match;

  assign len_clamped = (length > MAX_L) ? MAX_L : length;
  assign accept      = (state == IDLE) && start;

  // Compare stage only looks at words returned while the scan is live, so any
  // read still in flight when an early exit jumps to FIN is dropped.
  assign match = pipe_vld && ((state == ISSUE) || (state == DRAIN)) &&
                 (rd_data == query_q) && !hit;

  assign rd_en   = (state == ISSUE);
  assign rd_addr = idx[AW-1:0];
  assign busy    = (state == ISSUE) || (state == DRAIN);
  assign done    = (state == FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len_clamped <= START_IDX) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (idx == len_q - 8'd1) begin
          state_nxt = DRAIN;
        end
`ifdef SCAN_EARLY_EXIT_EN
        if (match) begin
          state_nxt = FIN;
        end
`endif
      end
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      query_q   <= '0;
      len_q     <= '0;
      idx       <= '0;
      idx_pipe  <= '0;
      pipe_vld  <= 1'b0;
      hit       <= 1'b0;
      hit_index <= '0;
    end else begin
      pipe_vld <= (state == ISSUE);
      idx_pipe <= idx;
      if (accept) begin
        query_q   <= query_xy;
        len_q     <= len_clamped;
        idx       <= START_IDX;
        hit       <= 1'b0;
        hit_index <= '0;
      end else if (state == ISSUE) begin
        idx <= idx + 8'd1;
      end
      if (match) begin
        hit       <= 1'b1;
        hit_index <= idx_pipe;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_scan.sv
// Scoreboard bench for snake_body_scan: stimulus pushes expected reads/results, a negedge monitor checks them.
// Expected values follow the SCAN_EARLY_EXIT_EN build setting when that macro is defined.
module tb_snake_body_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] query_xy;
  logic [7:0]  length;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [10:0] rd_data;
  logic        busy;
  logic        done;
  logic        hit;
  logic [7:0]  hit_index;

  logic [10:0] mem [0:127];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  int   addr_q[$];
  logic exp_hit_q[$];
  int   exp_idx_q[$];
  int   exp_cyc_q[$];

  always #5 clk = ~clk;

  snake_body_scan dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .query_xy  (query_xy),
    .length    (length),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_index (hit_index)
  );

  // Synchronous segment store: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: cycle counter plus scoreboard pops on rd_en and done.
  always @(negedge clk) begin
    int e_addr, e_idx, e_cyc;
    logic e_hit;
    cyc++;
    if (mon_en) begin
      if (rd_en) begin
        if (addr_q.size() == 0) begin
          check("unexpected_rd_en", 1, 0);
        end else begin
          e_addr = addr_q.pop_front();
          check("rd_addr", int'(rd_addr), e_addr);
        end
      end
      if (done) begin
        if (exp_cyc_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e_hit = exp_hit_q.pop_front();
          e_idx = exp_idx_q.pop_front();
          e_cyc = exp_cyc_q.pop_front();
          check("done_cycle", cyc, e_cyc);
          check("hit", int'(hit), int'(e_hit));
          check("hit_index", int'(hit_index), e_idx);
          check("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic run_scan(input int len, input logic [10:0] q, input logic eh,
                          input int ei, input int nrd_full, input int lat_full,
                          input int nrd_ee, input int lat_ee,
                          input bit change_mid, input bit pulse_busy);
    int nrd, lat;
`ifdef SCAN_EARLY_EXIT_EN
    nrd = nrd_ee;  lat = lat_ee;
`else
    nrd = nrd_full; lat = lat_full;
`endif
    @(negedge clk); #1;
    for (int a = 1; a <= nrd; a++) addr_q.push_back(a);
    exp_hit_q.push_back(eh);
    exp_idx_q.push_back(ei);
    exp_cyc_q.push_back(cyc + lat);
    length   = 8'(len);
    query_xy = q;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < lat + 3; c++) begin
      @(negedge clk);
      if (change_mid && c == 3) begin
        length   = 8'd3;
        query_xy = 11'd101;
      end
      if (pulse_busy && (c == 5 || c == 60 || c == 126 || c == 128)) begin
        start  = 1'b1;
        length = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 11'(i + 100);
    reset    = 1'b1;
    start    = 1'b0;
    query_xy = '0;
    length   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_hit_index", int'(hit_index), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // len, query, hit, idx, reads/lat full, reads/lat early-exit
    run_scan(5,   11'd102,  1'b1, 2,   4,   6,   3,   4,   1'b0, 1'b0);
    run_scan(1,   11'd100,  1'b0, 0,   0,   1,   0,   1,   1'b0, 1'b0);
    run_scan(0,   11'd102,  1'b0, 0,   0,   1,   0,   1,   1'b0, 1'b0);
    run_scan(2,   11'd100,  1'b0, 0,   1,   3,   1,   3,   1'b0, 1'b0);
    mem[7] = 11'd103;
    run_scan(10,  11'd103,  1'b1, 3,   9,   11,  4,   5,   1'b0, 1'b0);
    @(negedge clk);
    check("hold_hit", int'(hit), 1);
    check("hold_hit_index", int'(hit_index), 3);
    run_scan(10,  11'd2047, 1'b0, 0,   9,   11,  9,   11,  1'b0, 1'b0);
    run_scan(200, 11'd227,  1'b1, 127, 127, 129, 127, 129, 1'b0, 1'b1);
    run_scan(10,  11'd105,  1'b1, 5,   9,   11,  6,   7,   1'b1, 1'b0);

    // Reset in the middle of a long scan.
    mon_en = 1'b0;
    @(negedge clk); #1;
    length   = 8'd20;
    query_xy = 11'd115;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_rd_en", int'(rd_en), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rd_en", int'(rd_en), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_rd_en", int'(rd_en), 0);
    check("post_rst_done", int'(done), 0);
    check("post_rst_hit", int'(hit), 0);
    mon_en = 1'b1;
    run_scan(5,   11'd102,  1'b1, 2,   4,   6,   3,   4,   1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("leftover_reads", addr_q.size(), 0);
    check("leftover_results", exp_cyc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
